nzcv_flag_unit: RTL
===================

Name: nzcv_flag_unit

Overview:
- Producer side of the NZCV status flags that the conditional-execution unit consumes.
- Executes ADD/SUB/AND/ORR on two signed 32-bit operands and registers the result.
- When set_flags is asserted, updates the architectural flag register, bit order [N=3, Z=2, C=1, V=0].
- Provides a LIFO shadow stack to save and restore flags on exception entry and return.

Parameters:
- STACK_DEPTH, 4, number of saved flag entries (>=1).
- FLAGS_RST, 4'b0000, flag register value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- op_valid  in  1  operation present this cycle.
- op_kind  in  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- op_a  in  32  signed operand A.
- op_b  in  32  signed operand B.
- set_flags  in  1  update flags from this op (ignored unless op_valid).
- save  in  1  push current flags onto shadow stack.
- restore  in  1  pop top of stack into flag register.
- result  out  32  registered op result.
- result_valid  out  1  one-cycle pulse, cycle after accepted op.
- flags  out  4  architectural NZCV register.
- stack_level  out  $clog2(STACK_DEPTH+1)  entries held.
- err  out  1  one-cycle pulse on illegal stack request.

Behaviour:
- Reset, when rst_n=0 at a clock edge:
  - result=0, result_valid=0, flags=FLAGS_RST, stack_level=0, err=0.
  - Reset aborts any op in flight; no result_valid follows.
- Latency:
  - op accepted at edge k produces result/result_valid/flags after edge k+1 (1 cycle).
  - No backpressure; an op is accepted every cycle.
- ADD: {c,r} = {1'b0,a} + {1'b0,b} (33-bit).
  - C = c.
  - V = (a[31]==b[31]) && (r[31]!=a[31]).
- SUB: {c,r} = {1'b0,a} + {1'b0,~b} + 1.
  - C = c (1 = no borrow, a>=b unsigned).
  - V = (a[31]!=b[31]) && (r[31]!=a[31]).
- AND/ORR: r = a&b or a|b; C and V are preserved from the current register.
- All ops: N = r[31], Z = (r==0).
- op_valid with set_flags=0: result updates, flags unchanged.
- Save:
  - Pushes flags as held before this cycle's update.
  - If stack_level==STACK_DEPTH: no push, err=1.
- Restore:
  - Flags load the top entry, stack_level decrements.
  - If stack_level==0: flags unchanged, err=1.
- Simultaneous events:
  - save+restore in the same cycle: illegal; neither acts, err=1; any op still proceeds.
  - restore + op with set_flags: restore wins the flag write; result still updates and result_valid still pulses.
  - save + op with set_flags: pushed value is pre-op; flags then take the op's value.
- The stack is a pure LIFO; no wrap-around. Entries above stack_level are don't-care.
- err is a single pulse per offending cycle.
- No internal FSM beyond the stack pointer and output registers. stack_level saturates at both ends as described.

Decomposition:
- Shared package nzcv_pkg holds:
  - op_kind constants OP_ADD, OP_SUB, OP_AND, OP_ORR.
  - Flag bit indices F_N=3, F_Z=2, F_C=1, F_V=0.
  - A 4-bit flags typedef, reused by the conditional-execution unit.
- One sub-module, flag_stack: parameterised LIFO with push, pop, top, level, full, empty.
- Arithmetic and flag derivation stay in the top level.

Test Plan:
- SUB a=5, b=5, set_flags=1: next cycle result=0, flags=4'b0110.
- ADD a=32'h7FFFFFFF, b=1, set_flags=1: result=32'h80000000, flags=4'b1001.
- SUB a=0, b=1: result=32'hFFFFFFFF, flags=4'b1000. Then AND a=0, b=-1, set_flags=1: flags=4'b0100 (C,V kept 0).
- Load flags=4'b0110. Then save with concurrent ADD 1+1 set_flags=1: flags=4'b0000, stack_level=1. Then restore: flags=4'b0110, stack_level=0.
- STACK_DEPTH=4: 5 consecutive saves, where the 5th gives err=1 and stack_level=4. Then 5 restores, where the 5th gives err=1, stack_level=0, flags unchanged.
- Drive op_valid with rst_n=0 on the same edge: result_valid stays 0, flags=FLAGS_RST. Separately, save+restore together gives err=1 and stack_level unchanged.

Source files
------------

// File: rtl/nzcv_pkg.sv
// Shared definitions for the NZCV status-flag producer and its consumers.
// Holds the opcode encoding, the flag bit positions and the flags type.
package nzcv_pkg;

  typedef logic [3:0] flags_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_ORR = 2'b11;

  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

endpackage

// File: rtl/flag_stack.sv
// LIFO shadow stack for saved flag values.
// The stack never wraps; the caller is expected to gate push on full and pop on empty.
module flag_stack
  import nzcv_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic                             pop,
  input  flags_t                           push_data,
  output flags_t                           top,
  output logic [$clog2(STACK_DEPTH+1)-1:0] level,
  output logic                             full,
  output logic                             empty
);

  localparam int LW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  flags_t          entries_r [STACK_DEPTH];
  logic [LW-1:0]   level_r;
  logic [LW-1:0]   top_ptr_s;

  assign full  = (level_r == LW'(STACK_DEPTH));
  assign empty = (level_r == {LW{1'b0}});
  assign level = level_r;

  // Select the most recently pushed entry; reads as zero when empty.
  always_comb begin
    top_ptr_s = level_r - {{(LW-1){1'b0}}, 1'b1};
    if (empty) begin
      top = 4'b0000;
    end else begin
      top = entries_r[top_ptr_s[IW-1:0]];
    end
  end

  // Stack pointer and storage update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_r <= {LW{1'b0}};
      for (int i = 0; i < STACK_DEPTH; i++) begin
        entries_r[i] <= 4'b0000;
      end
    end else if (push && !pop && !full) begin
      entries_r[level_r[IW-1:0]] <= push_data;
      level_r                    <= level_r + {{(LW-1){1'b0}}, 1'b1};
    end else if (pop && !push && !empty) begin
      level_r <= top_ptr_s;
    end else begin
      level_r <= level_r;
    end
  end

endmodule

// File: rtl/nzcv_flag_unit.sv
// ALU result and NZCV flag producer with a shadow stack for exception save/restore.
// Arithmetic and flag derivation live here; flag_stack only stores entries.
module nzcv_flag_unit
  import nzcv_pkg::*;
#(
  parameter int     STACK_DEPTH = 4,
  parameter flags_t FLAGS_RST   = 4'b0000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             op_valid,
  input  logic [1:0]                       op_kind,
  input  logic [31:0]                      op_a,
  input  logic [31:0]                      op_b,
  input  logic                             set_flags,
  input  logic                             save,
  input  logic                             restore,
  output logic [31:0]                      result,
  output logic                             result_valid,
  output flags_t                           flags,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
  output logic                             err
);

  logic [31:0] result_r;
  logic        result_valid_r;
  flags_t      flags_r;
  logic        err_r;

  logic [32:0] sum_s;
  logic [32:0] diff_s;
  logic [31:0] res_s;
  flags_t      op_flags_s;
  flags_t      flags_next_s;
  flags_t      stack_top_s;
  logic        stack_full_s;
  logic        stack_empty_s;
  logic        do_push_s;
  logic        do_pop_s;
  logic        err_next_s;

  assign sum_s  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_s = {1'b0, op_a} + {1'b0, ~op_b} + 33'd1;

  // Result and flag derivation; logical ops carry C and V through unchanged.
  always_comb begin
    res_s      = 32'd0;
    op_flags_s = flags_r;
    case (op_kind)
      OP_ADD: begin
        res_s           = sum_s[31:0];
        op_flags_s[F_C] = sum_s[32];
        op_flags_s[F_V] = (op_a[31] == op_b[31]) && (sum_s[31] != op_a[31]);
      end
      OP_SUB: begin
        res_s           = diff_s[31:0];
        op_flags_s[F_C] = diff_s[32];
        op_flags_s[F_V] = (op_a[31] != op_b[31]) && (diff_s[31] != op_a[31]);
      end
      OP_AND:  res_s = op_a & op_b;
      OP_ORR:  res_s = op_a | op_b;
      default: res_s = 32'd0;
    endcase
    op_flags_s[F_N] = res_s[31];
    op_flags_s[F_Z] = (res_s == 32'd0);
  end

  // Stack request arbitration: a simultaneous save and restore is rejected outright.
  always_comb begin
    do_push_s  = save && !restore && !stack_full_s;
    do_pop_s   = restore && !save && !stack_empty_s;
    err_next_s = (save && restore)
              || (save && !restore && stack_full_s)
              || (restore && !save && stack_empty_s);
    if (do_pop_s) begin
      flags_next_s = stack_top_s;
    end else if (op_valid && set_flags) begin
      flags_next_s = op_flags_s;
    end else begin
      flags_next_s = flags_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_r       <= 32'd0;
      result_valid_r <= 1'b0;
      flags_r        <= FLAGS_RST;
      err_r          <= 1'b0;
    end else begin
      result_r       <= op_valid ? res_s : result_r;
      result_valid_r <= op_valid;
      flags_r        <= flags_next_s;
      err_r          <= err_next_s;
    end
  end

  flag_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (do_push_s),
    .pop      (do_pop_s),
    .push_data(flags_r),
    .top      (stack_top_s),
    .level    (stack_level),
    .full     (stack_full_s),
    .empty    (stack_empty_s)
  );

  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign flags        = flags_r;
  assign err          = err_r;

endmodule
